// File: rtl/pcie_vc_rx_queue_pkg.sv
// Shared PCIe transaction-layer definitions for the RX virtual-channel queue.
package pcie_vc_rx_queue_pkg;

    localparam int PCIe_TL_TLP_PACKET_SIZE = 224;
    localparam int PCIe_DATA_PAYLOAD_SIZE  = 128;
    localparam int PCIe_TLP_HEADER_SIZE    = 96;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic        r0;
        logic [2:0]  tc;
        logic [3:0]  r1;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [1:0]  at;
        logic [9:0]  length;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [31:0] addr;
    } tlp_memory_header_t;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_idx_e;

    function automatic vc_idx_e vc_other(input vc_idx_e v);
        return (v == VC0) ? VC1 : VC0;
    endfunction

endpackage

// File: rtl/pcie_vc_rx_queue_fifo.sv
// Per-VC TLP FIFO: circular buffer with wrap-bit pointers and first-word-fall-through read.
module pcie_vc_fifo
    import pcie_vc_rx_queue_pkg::*;
#(
    parameter int TLP_W = PCIe_TL_TLP_PACKET_SIZE,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wren_i,
    input  logic [TLP_W-1:0] wdata_i,
    output logic             full_o,
    input  logic             rden_i,
    output logic [TLP_W-1:0] rdata_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [TLP_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      wptr_d;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Blocked pushes/pops never move a pointer, so full/empty stay purely state-derived.
    always_comb begin
        do_push_s = wren_i && !full_o;
        do_pop_s  = rden_i && !empty_o;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (do_push_s) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pcie_vc_rx_queue.sv
// Receive VC queueing stage: two per-VC FIFOs drained round-robin into one held output register.
module pcie_vc_rx_queue
    import pcie_vc_rx_queue_pkg::*;
#(
    parameter int TLP_W = PCIe_TL_TLP_PACKET_SIZE,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vc0_wren_i,
    input  logic [TLP_W-1:0] vc0_wdata_i,
    output logic             vc0_full_o,
    output logic             vc0_empty_o,
    input  logic             vc1_wren_i,
    input  logic [TLP_W-1:0] vc1_wdata_i,
    output logic             vc1_full_o,
    output logic             vc1_empty_o,
    input  logic             fc_valid_i,
    input  logic             tlp_ready_i,
    output logic             tlp_valid_o,
    output logic [TLP_W-1:0] tlp_o
);

    logic [TLP_W-1:0] vc0_rdata_s;
    logic [TLP_W-1:0] vc1_rdata_s;
    logic             vc0_rden_s;
    logic             vc1_rden_s;
    logic             slot_free_s;
    logic             load_s;
    vc_idx_e          grant_s;
    vc_idx_e          last_grant_q;
    vc_idx_e          last_grant_d;
    logic             tlp_valid_q;
    logic             tlp_valid_d;
    logic [TLP_W-1:0] tlp_q;
    logic [TLP_W-1:0] tlp_d;

    pcie_vc_fifo #(.TLP_W(TLP_W), .DEPTH(DEPTH)) u_vc0_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wren_i  (vc0_wren_i),
        .wdata_i (vc0_wdata_i),
        .full_o  (vc0_full_o),
        .rden_i  (vc0_rden_s),
        .rdata_o (vc0_rdata_s),
        .empty_o (vc0_empty_o)
    );

    pcie_vc_fifo #(.TLP_W(TLP_W), .DEPTH(DEPTH)) u_vc1_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wren_i  (vc1_wren_i),
        .wdata_i (vc1_wdata_i),
        .full_o  (vc1_full_o),
        .rden_i  (vc1_rden_s),
        .rdata_o (vc1_rdata_s),
        .empty_o (vc1_empty_o)
    );

    assign slot_free_s = !tlp_valid_q || tlp_ready_i;
    assign load_s      = slot_free_s && fc_valid_i && (!vc0_empty_o || !vc1_empty_o);

    // Grant selection and next output-register state; a held TLP is never retracted.
    always_comb begin
        grant_s      = VC0;
        vc0_rden_s   = 1'b0;
        vc1_rden_s   = 1'b0;
        last_grant_d = last_grant_q;
        tlp_valid_d  = tlp_valid_q;
        tlp_d        = tlp_q;
        if (!vc0_empty_o && !vc1_empty_o) begin
            grant_s = vc_other(last_grant_q);
        end else if (!vc0_empty_o) begin
            grant_s = VC0;
        end else begin
            grant_s = VC1;
        end
        if (load_s) begin
            vc0_rden_s   = (grant_s == VC0);
            vc1_rden_s   = (grant_s == VC1);
            last_grant_d = grant_s;
            tlp_valid_d  = 1'b1;
            tlp_d        = (grant_s == VC0) ? vc0_rdata_s : vc1_rdata_s;
        end else if (tlp_valid_q && tlp_ready_i) begin
            tlp_valid_d = 1'b0;
        end else begin
            tlp_valid_d = tlp_valid_q;
        end
    end

    // Output register and round-robin state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= VC1;
            tlp_valid_q  <= 1'b0;
            tlp_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tlp_valid_q  <= tlp_valid_d;
            tlp_q        <= tlp_d;
        end
    end

    assign tlp_valid_o = tlp_valid_q;
    assign tlp_o       = tlp_q;

endmodule

// File: tb/tb_pcie_vc_rx_queue.sv
// Directed self-checking bench for pcie_vc_rx_queue.
module tb_pcie_vc_rx_queue;

    localparam int TLP_W = 224;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             vc0_wren_i;
    logic [TLP_W-1:0] vc0_wdata_i;
    logic             vc0_full_o;
    logic             vc0_empty_o;
    logic             vc1_wren_i;
    logic [TLP_W-1:0] vc1_wdata_i;
    logic             vc1_full_o;
    logic             vc1_empty_o;
    logic             fc_valid_i;
    logic             tlp_ready_i;
    logic             tlp_valid_o;
    logic [TLP_W-1:0] tlp_o;

    int n_assert = 0;
    int n_fail   = 0;

    pcie_vc_rx_queue #(.TLP_W(TLP_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vc0_wren_i  (vc0_wren_i),
        .vc0_wdata_i (vc0_wdata_i),
        .vc0_full_o  (vc0_full_o),
        .vc0_empty_o (vc0_empty_o),
        .vc1_wren_i  (vc1_wren_i),
        .vc1_wdata_i (vc1_wdata_i),
        .vc1_full_o  (vc1_full_o),
        .vc1_empty_o (vc1_empty_o),
        .fc_valid_i  (fc_valid_i),
        .tlp_ready_i (tlp_ready_i),
        .tlp_valid_o (tlp_valid_o),
        .tlp_o       (tlp_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [TLP_W-1:0] d);
        chk({tag, "_valid"}, {255'd0, tlp_valid_o}, {255'd0, v});
        chk({tag, "_data"}, {32'd0, tlp_o}, {32'd0, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        vc0_wren_i  = 1'b0;
        vc0_wdata_i = '0;
        vc1_wren_i  = 1'b0;
        vc1_wdata_i = '0;
        fc_valid_i  = 1'b0;
        tlp_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_vc0_empty", {255'd0, vc0_empty_o}, {255'd0, 1'b1});
        chk("rst_vc1_empty", {255'd0, vc1_empty_o}, {255'd0, 1'b1});
        chk("rst_vc0_full", {255'd0, vc0_full_o}, {255'd0, 1'b0});
        chk("rst_vc1_full", {255'd0, vc1_full_o}, {255'd0, 1'b0});
        chk_out("rst_out", 1'b0, 224'h0);
        rst_n = 1'b1;
        tick();

        // Single VC streaming: first output two edges after first push.
        fc_valid_i  = 1'b1;
        tlp_ready_i = 1'b1;
        vc0_wren_i  = 1'b1;
        vc0_wdata_i = 224'hA1;
        tick();
        chk_out("single_lat1", 1'b0, 224'h0);
        vc0_wdata_i = 224'hA2;
        tick();
        chk_out("single_a1", 1'b1, 224'hA1);
        vc0_wdata_i = 224'hA3;
        tick();
        chk_out("single_a2", 1'b1, 224'hA2);
        vc0_wren_i = 1'b0;
        tick();
        chk_out("single_a3", 1'b1, 224'hA3);
        tick();
        chk_out("single_idle", 1'b0, 224'hA3);
        chk("single_empty", {255'd0, vc0_empty_o}, {255'd0, 1'b1});

        // Round-robin from reset state.
        do_reset();
        fc_valid_i  = 1'b0;
        vc0_wren_i  = 1'b1;
        vc1_wren_i  = 1'b1;
        vc0_wdata_i = 224'h01;
        vc1_wdata_i = 224'h11;
        tick();
        vc0_wdata_i = 224'h02;
        vc1_wdata_i = 224'h12;
        tick();
        vc0_wren_i = 1'b0;
        vc1_wren_i = 1'b0;
        tick();
        chk_out("rr_gated", 1'b0, 224'h0);
        fc_valid_i = 1'b1;
        tick();
        chk_out("rr_0", 1'b1, 224'h01);
        tick();
        chk_out("rr_1", 1'b1, 224'h11);
        tick();
        chk_out("rr_2", 1'b1, 224'h02);
        tick();
        chk_out("rr_3", 1'b1, 224'h12);
        tick();
        chk_out("rr_idle", 1'b0, 224'h12);

        // Backpressure: hold 0x55 for five cycles, 0x56 stays queued.
        tlp_ready_i = 1'b0;
        vc0_wren_i  = 1'b1;
        vc0_wdata_i = 224'h55;
        tick();
        vc0_wdata_i = 224'h56;
        tick();
        vc0_wren_i = 1'b0;
        chk_out("bp_load", 1'b1, 224'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 224'h55);
            chk("bp_no_pop", {255'd0, vc0_empty_o}, {255'd0, 1'b0});
        end
        tlp_ready_i = 1'b1;
        tick();
        chk_out("bp_next", 1'b1, 224'h56);
        tick();
        chk_out("bp_idle", 1'b0, 224'h56);
        chk("bp_empty", {255'd0, vc0_empty_o}, {255'd0, 1'b1});

        // Overflow of VC1: words 16 and 17 are dropped.
        fc_valid_i = 1'b0;
        vc1_wren_i = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            vc1_wdata_i = TLP_W'(i);
            tick();
            if (i == DEPTH - 2) begin
                chk("ovf_not_full", {255'd0, vc1_full_o}, {255'd0, 1'b0});
            end
            if (i == DEPTH - 1) begin
                chk("ovf_full", {255'd0, vc1_full_o}, {255'd0, 1'b1});
            end
        end
        vc1_wren_i = 1'b0;
        chk("ovf_still_full", {255'd0, vc1_full_o}, {255'd0, 1'b1});
        fc_valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk_out("ovf_drain", 1'b1, TLP_W'(i));
        end
        chk("ovf_empty", {255'd0, vc1_empty_o}, {255'd0, 1'b1});
        tick();
        chk_out("ovf_idle", 1'b0, TLP_W'(DEPTH - 1));

        // Flow-control gating.
        fc_valid_i  = 1'b0;
        vc0_wren_i  = 1'b1;
        vc0_wdata_i = 224'h77;
        tick();
        vc0_wdata_i = 224'h78;
        tick();
        vc0_wren_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fc_no_valid", {255'd0, tlp_valid_o}, {255'd0, 1'b0});
        end
        tlp_ready_i = 1'b0;
        fc_valid_i  = 1'b1;
        tick();
        chk_out("fc_load", 1'b1, 224'h77);
        fc_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("fc_hold", 1'b1, 224'h77);
        end
        tlp_ready_i = 1'b1;
        tick();
        chk_out("fc_accept", 1'b0, 224'h77);
        chk("fc_queued", {255'd0, vc0_empty_o}, {255'd0, 1'b0});
        fc_valid_i = 1'b1;
        tick();
        chk_out("fc_resume", 1'b1, 224'h78);

        // Asynchronous reset mid-stream with three TLPs queued and one held.
        fc_valid_i  = 1'b0;
        tlp_ready_i = 1'b0;
        vc1_wren_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vc1_wdata_i = TLP_W'(32'h91 + i);
            tick();
        end
        vc1_wren_i = 1'b0;
        fc_valid_i = 1'b1;
        tick();
        chk_out("mid_held", 1'b1, 224'h78);
        chk("mid_vc1_busy", {255'd0, vc1_empty_o}, {255'd0, 1'b0});
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst_async", 1'b0, 224'h0);
        chk("mid_rst_vc1_empty", {255'd0, vc1_empty_o}, {255'd0, 1'b1});
        chk("mid_rst_vc0_empty", {255'd0, vc0_empty_o}, {255'd0, 1'b1});
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("mid_after_rst", 1'b0, 224'h0);
        chk("mid_after_vc1_empty", {255'd0, vc1_empty_o}, {255'd0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_vc_rx_queue.md
Name: pcie_vc_rx_queue

Overview:
- Receive-side virtual-channel queueing stage of the PCIe transaction layer: two TLP FIFOs (VC0, VC1) plus an arbiter that drains them onto one ready/valid TLP output.
- The upstream TL RX unpacker steers each TLP by header TC[0]: 0 goes to VC0, 1 goes to VC1.
- The output feeds the AXI read-data path (rvalid/rready/rdata).
- Draining is gated by the flow-control credit signal.

Parameters:
- TLP_W, 224: TLP width, 96-bit header plus 128-bit payload. Taken from PCIe_PKG::PCIe_TL_TLP_PACKET_SIZE.
- DEPTH, 16: entries per VC FIFO. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- vc0_wren_i  in  1  VC0 push
- vc0_wdata_i  in  TLP_W  VC0 push data
- vc0_full_o  out  1  VC0 FIFO full
- vc0_empty_o  out  1  VC0 FIFO empty
- vc1_wren_i  in  1  VC1 push
- vc1_wdata_i  in  TLP_W  VC1 push data
- vc1_full_o  out  1  VC1 FIFO full
- vc1_empty_o  out  1  VC1 FIFO empty
- fc_valid_i  in  1  flow-control credit available; high enables draining
- tlp_ready_i  in  1  downstream ready
- tlp_valid_o  out  1  output TLP valid
- tlp_o  out  TLP_W  output TLP

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state updates on the posedge of clk.
- Reset values:
  - Both FIFOs empty: full_o=0, empty_o=1, pointers 0.
  - tlp_valid_o=0, tlp_o=0.
  - Round-robin pointer last_grant=VC1, so VC0 wins the first tie.
  - Asserting rst_n mid-operation discards all queued and held TLPs immediately.
- FIFO (per VC):
  - Circular buffer with log2(DEPTH)+1-bit read/write pointers.
  - full_o = (pointer MSBs differ and low bits equal). empty_o = (pointers equal). Both are registered-state derived, with no combinational path from wren/rden.
  - A push with full_o=1 is ignored: no overwrite, no pointer change. A pop with empty_o=1 is ignored.
  - Push and pop in the same cycle on a non-full, non-empty FIFO both occur; occupancy is unchanged.
  - Push on an empty FIFO plus a pop in the same cycle: only the push takes effect.
  - Push while full plus a pop: only the pop takes effect.
  - rdata is first-word-fall-through: it always presents mem[rptr]. Its value is undefined when empty.
  - Storage has no reset.
- Arbiter:
  - Single output register holding tlp_o and tlp_valid_o.
  - slot_free = !tlp_valid_o || tlp_ready_i.
  - Load condition: slot_free && fc_valid_i && (!vc0_empty || !vc1_empty).
  - Grant on load:
    - Only one VC non-empty: that VC is granted.
    - Both non-empty: the VC other than last_grant is granted (round-robin). last_grant is updated to the granted VC.
  - rden is asserted combinationally to exactly the granted FIFO in the load cycle. At the same edge tlp_o <= granted head and tlp_valid_o <= 1.
  - No load and tlp_valid_o && tlp_ready_i: tlp_valid_o <= 0. tlp_o keeps its last value.
  - tlp_valid_o && !tlp_ready_i: tlp_o and tlp_valid_o hold stable (AXI-style). fc_valid_i deasserting never retracts a valid TLP.
  - fc_valid_i=0: no new loads, no FIFO pops.
- Latency:
  - A push at edge k clears empty after edge k.
  - tlp_valid_o rises after edge k+1 when fc_valid_i=1 and the slot is free.
  - Back-to-back throughput is 1 TLP/cycle when tlp_ready_i is held high.
- Ordering: FIFO order is preserved within each VC. There is no ordering guarantee between VCs.

Decomposition:
- PCIe_PKG (shared package): PCIe_TL_TLP_PACKET_SIZE (224), PCIe_DATA_PAYLOAD_SIZE (128), tlp_memory_header packed struct (96 bits, including tc field). A VC index typedef is optional.
- Sub-module: pcie_vc_fifo, parameterized TLP_W/DEPTH, instantiated twice. Ports: clk, rst_n, wren_i, wdata_i, full_o, rden_i, rdata_o, empty_o.
- Arbiter and output register live in the top module.

Test Plan:
- Reset: after reset, vc0_empty_o=vc1_empty_o=1, full_o=0, tlp_valid_o=0, tlp_o=0.
  - Drive rst_n low mid-stream with 3 TLPs queued: all empty next cycle, tlp_valid_o=0.
- Single VC: fc_valid_i=1, tlp_ready_i=1. Push 0xA1, 0xA2, 0xA3 to VC0 on consecutive cycles.
  - tlp_o = 0xA1, 0xA2, 0xA3 on consecutive cycles, the first appearing 2 edges after the first push.
- Round-robin: preload VC0 with {0x01,0x02} and VC1 with {0x11,0x12} while fc_valid_i=0, then raise fc_valid_i.
  - Output order is 0x01, 0x11, 0x02, 0x12.
- Backpressure: tlp_ready_i=0 with 0x55 presented.
  - tlp_o stays 0x55 with valid=1 for 5 cycles, with no FIFO pop.
  - Raise ready: the next TLP follows in the next cycle.
- Full/overflow: fc_valid_i=0. Push DEPTH+2 words 0..17 into VC1.
  - vc1_full_o=1 after 16 pushes; words 16 and 17 are dropped.
  - After draining, exactly words 0..15 appear in order; empty_o=1 at the end.
- Flow control gating: queue 2 TLPs, fc_valid_i=0.
  - No valid output for 10 cycles.
  - Drop fc_valid_i while a TLP is presented and not accepted: it stays valid until tlp_ready_i.
